// File: rtl/dbx_pipe_if.sv
// Beat-level handshake bundle for dbx_pipe: upstream valid/ready, mode and
// data, plus downstream valid/ready, data, mode, zero-plane mask and busy.
// The master modport is the side that feeds and drains the block; the slave
// modport is the block itself.
interface dbx_pipe_if #(
    parameter int SYM_W   = 8,
    parameter int NUM_SYM = 32
);
    localparam int DW = SYM_W * NUM_SYM;

    logic             valid_i;
    logic             ready_o;
    logic             mode_i;
    logic [DW-1:0]    data_i;
    logic             valid_o;
    logic             ready_i;
    logic [DW-1:0]    data_o;
    logic             mode_o;
    logic [SYM_W-1:0] zmask_o;
    logic             busy_o;

    modport master (
        output valid_i, mode_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, mode_o, zmask_o, busy_o
    );

    modport slave (
        input  valid_i, mode_i, data_i, ready_i,
        output ready_o, valid_o, data_o, mode_o, zmask_o, busy_o
    );
endinterface

// File: rtl/dbx_pipe.sv
// dbx_pipe: two-stage pipelined delta bitplane-XOR transform.
// Forward (mode 0) transposes NUM_SYM symbols of SYM_W bits into SYM_W planes
// and XORs every plane (except column 0) with the plane above it. Inverse
// (mode 1) undoes this with a prefix XOR down the planes and transposes back.
// Optional build macro DBX_PIPE_ZMASK_EN enables the per-plane all-zero flags
// on zmask_o (forward beats only); without it zmask_o is tied to zero.
module dbx_pipe #(
    parameter int SYM_W   = 8,
    parameter int NUM_SYM = 32
) (
    input logic        clk,
    input logic        rst_n,
    dbx_pipe_if.slave  bus
);
    localparam int DW = SYM_W * NUM_SYM;

    // Symbol s bit b lives at d[(NUM_SYM-s)*SYM_W-1-b]; plane b bit s lives
    // at q[(SYM_W-b)*NUM_SYM-1-s]. Column s=0 is never XORed.
    function automatic logic [DW-1:0] fwd_xform(input logic [DW-1:0] d);
        logic [DW-1:0] q;
        logic          pbit;
        q = '0;
        for (int b = 0; b < SYM_W; b++) begin
            for (int s = 0; s < NUM_SYM; s++) begin
                pbit = d[(NUM_SYM-s)*SYM_W-1-b];
                if (b > 0 && s > 0)
                    pbit = pbit ^ d[(NUM_SYM-s)*SYM_W-b];
                q[(SYM_W-b)*NUM_SYM-1-s] = pbit;
            end
        end
        return q;
    endfunction

    // Prefix XOR down the planes per column, written straight back into
    // symbol order so no separate transpose pass is needed.
    function automatic logic [DW-1:0] inv_xform(input logic [DW-1:0] q);
        logic [DW-1:0] r;
        logic          acc;
        logic          rbit;
        r = '0;
        for (int s = 0; s < NUM_SYM; s++) begin
            acc = 1'b0;
            for (int b = 0; b < SYM_W; b++) begin
                rbit = q[(SYM_W-b)*NUM_SYM-1-s];
                if (s > 0)
                    rbit = rbit ^ acc;
                acc = rbit;
                r[(NUM_SYM-s)*SYM_W-1-b] = rbit;
            end
        end
        return r;
    endfunction

`ifdef DBX_PIPE_ZMASK_EN
    // Flag per packed plane; plane 0 maps to the MSB of the mask.
    function automatic logic [SYM_W-1:0] zero_planes(input logic [DW-1:0] q);
        logic [SYM_W-1:0] zm;
        zm = '0;
        for (int b = 0; b < SYM_W; b++)
            zm[SYM_W-1-b] = ~|q[(SYM_W-b)*NUM_SYM-1 -: NUM_SYM];
        return zm;
    endfunction
`endif

    logic          vld_p1;
    logic          vld_p2;
    logic          mode_p1;
    logic          mode_p2;
    logic [DW-1:0] data_p1;
    logic [DW-1:0] data_p2;
    logic          ld_p1;
    logic          ld_p2;
    logic [DW-1:0] fwd_p1;
    logic [DW-1:0] inv_p1;

    // A stage may load when it is empty or its contents move on this cycle.
    assign ld_p2 = !vld_p2 || bus.ready_i;
    assign ld_p1 = !vld_p1 || ld_p2;

    assign fwd_p1 = fwd_xform(data_p1);
    assign inv_p1 = inv_xform(data_p1);

    // Stage 1: capture the raw input beat and its mode on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            mode_p1 <= 1'b0;
            data_p1 <= '0;
        end else if (ld_p1) begin
            vld_p1 <= bus.valid_i;
            if (bus.valid_i) begin
                mode_p1 <= bus.mode_i;
                data_p1 <= bus.data_i;
            end
        end
    end

    // Stage 2: capture the transformed beat selected by its own mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            mode_p2 <= 1'b0;
            data_p2 <= '0;
        end else if (ld_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                mode_p2 <= mode_p1;
                data_p2 <= mode_p1 ? inv_p1 : fwd_p1;
            end
        end
    end

`ifdef DBX_PIPE_ZMASK_EN
    logic [SYM_W-1:0] zm_p2;

    // Stage 2 zero-plane mask, loaded in lockstep with the stage 2 data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zm_p2 <= '0;
        else if (ld_p2 && vld_p1)
            zm_p2 <= mode_p1 ? '0 : zero_planes(fwd_p1);
    end

    assign bus.zmask_o = zm_p2;
`else
    assign bus.zmask_o = '0;
`endif

    assign bus.ready_o = !vld_p1 || !vld_p2 || bus.ready_i;
    assign bus.valid_o = vld_p2;
    assign bus.data_o  = data_p2;
    assign bus.mode_o  = mode_p2;
    assign bus.busy_o  = vld_p1 || vld_p2;
endmodule

// File: doc/dbx_pipe.md
Name: dbx_pipe

Overview:
- Parametrised, pipelined successor to the combinational delta bitplane-XOR stage of the compressor.
- Forward mode: transposes NUM_SYM symbols of SYM_W bits into SYM_W bitplanes, then XORs each plane with the plane above it. Used on the compress path.
- Inverse mode: rebuilds the symbols from the XORed planes. Used on the decompress path.
- Two-stage register pipeline with valid/ready backpressure. Sits between the delta (diff) stage and the bitplane encoder.

Parameters:
- SYM_W, 8, bits per symbol = number of bitplanes (>=2).
- NUM_SYM, 32, symbols per beat = bits per plane (>=2).
- DW = SYM_W*NUM_SYM, derived localparam, data width (default 256).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept a beat this cycle.
- mode_i  in  1  0 = forward (symbols -> XORed planes), 1 = inverse.
- data_i  in  DW  input beat.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts.
- data_o  out  DW  output beat.
- mode_o  out  1  mode the beat was accepted with.
- zmask_o  out  SYM_W  per-plane all-zero flags (see Optional Feature).
- busy_o  out  1  any pipeline stage holds a beat.

Behaviour:
- Symbol indexing: symbol s (s=0..NUM_SYM-1) = data_i[(NUM_SYM-s)*SYM_W-1 -: SYM_W]. Symbol 0 is at the MSB end. Bit b=0 is the symbol MSB.
- Plane indexing: plane p[b] is NUM_SYM bits, with p[b][s] = bit b of symbol s. Packed output = {q[0], q[1], ..., q[SYM_W-1]}, and within each plane s=0 is the MSB.
- Forward transform:
  - q[0] = p[0].
  - q[b][0] = p[b][0] for b>=1.
  - q[b][s] = p[b][s] ^ p[b-1][s] for b>=1, s>=1.
- Inverse transform: input is interpreted as packed planes q.
  - r[0] = q[0].
  - r[b][0] = q[b][0].
  - r[b][s] = q[b][s] ^ r[b-1][s], i.e. prefix XOR down the planes.
  - r is then transposed back to symbols, packed as in data_i.
  - inverse(forward(x)) == x for all x.
- Pipeline:
  - Stage 1 registers data_i and mode_i on accept.
  - Stage 2 registers the transform result, mode and zmask.
  - Outputs come directly from stage-2 registers, no combinational path from data_i to data_o.
- Latency: exactly 2 cycles from accept (valid_i & ready_o) to valid_o when unstalled. Throughput is 1 beat/cycle.
- Handshake:
  - Stage 2 loads when !v2 or ready_i.
  - Stage 1 loads when !v1 or (stage 2 loads).
  - ready_o = !v1 | !v2 | ready_i (combinational).
  - Data in a stalled stage is held unchanged.
  - valid_o stays high until ready_i. data_o and mode_o are stable while valid_o & !ready_i.
- mode travels with its beat. Mixed-mode consecutive beats are legal and need no bubble.
- Simultaneous accept and emit with both stages full and ready_i=1: all stages shift, no beat is lost or duplicated.
- busy_o = v1 | v2.
- Reset: rst_n low asynchronously clears v1, v2, all data, mode and zmask registers to 0.
  - valid_o=0, data_o=0, mode_o=0, zmask_o=0, busy_o=0, ready_o=1 after reset.
  - Reset mid-operation discards in-flight beats.

Optional Feature:
- Macro DBX_PIPE_ZMASK_EN.
- Defined: zmask_o[SYM_W-1-b] = 1 iff output plane q[b] is all zero. Computed in stage 2 for forward-mode beats only; inverse-mode beats give zmask_o=0. The MSB of zmask_o corresponds to plane 0.
- Undefined: the zero-detect logic is not built and zmask_o is tied to 0. The port is always present.

Test Plan:
- Forward, defaults, data_i all 0xFF, ready_i=1 -> 2 cycles later data_o = {32'hFFFFFFFF, 7{32'h80000000}}, mode_o=0. With macro: zmask_o=8'h00.
- Forward, symbol 0 = 0x01 and all other symbols 0 -> data_o = 256'h8000_0000 (only bit 31 set). With macro: zmask_o=8'hFE.
- Inverse, data_i = {32'hFFFFFFFF, 7{32'h80000000}}, mode_i=1 -> data_o all 0xFF, mode_o=1, zmask_o=0. Random x: forward then inverse returns x for 1000 beats.
- Backpressure: stream 6 beats with ready_i=0 for cycles 3-7 -> ready_o falls after 2 beats held, valid_o/data_o stable while stalled, beats emerge in order with no loss or duplication. Alternate mode per beat.
- Reset: assert rst_n=0 asynchronously with 2 beats in flight -> valid_o/busy_o drop to 0 immediately. After release, ready_o=1 and the first new beat appears after 2 cycles.
- Parameter sweep SYM_W=4, NUM_SYM=16: symbol 0 = 0xF, others 0 -> data_o = {16'h8000, 3{16'h8000}}.
